// File: rtl/chatter_filter_bank.sv
// Purpose: bank of independent switch debouncers with press/release strobes and long-press detection.
// Latency: 2 synchronizer flops + PRESS_COUNT (RELEASE_COUNT) samples to a registered press (release).
// Backpressure: none; every channel samples every cycle and outputs cannot be stalled.
module chatter_filter_bank #(
  parameter int CHANNELS      = 4,
  parameter int CNT_WIDTH     = 8,
  parameter int PRESS_COUNT   = 30,
  parameter int RELEASE_COUNT = 30,
  parameter int LONG_WIDTH    = 16,
  parameter int LONG_COUNT    = 1000,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic                chatterclock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] switchin,
  output logic [CHANNELS-1:0] ispressedout,
  output logic [CHANNELS-1:0] pressedpulse,
  output logic [CHANNELS-1:0] releasedpulse,
  output logic [CHANNELS-1:0] longpressout,
  output logic                anypressed
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // Raw level of an unpressed switch; also the synchronizer reset value.
  localparam logic INACTIVE = (ACTIVE_LOW != 0);

  // Counters compare against "last" values so a qualifying sample lands on the Nth edge.
  localparam logic [CNT_WIDTH-1:0]  PRESS_LAST   = CNT_WIDTH'(PRESS_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0]  RELEASE_LAST = CNT_WIDTH'(RELEASE_COUNT - 1);
  localparam logic [LONG_WIDTH-1:0] LONG_LAST    = LONG_WIDTH'(LONG_COUNT - 1);
  localparam logic [LONG_WIDTH-1:0] LONG_MAX     = LONG_WIDTH'(LONG_COUNT);

  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;
  logic [CHANNELS-1:0] active;

  // Two-flop synchronizer on the raw switch inputs, parked at the inactive level in reset.
  always_ff @(posedge chatterclock or posedge reset) begin
    if (reset) begin
      sync1 <= {CHANNELS{INACTIVE}};
      sync2 <= {CHANNELS{INACTIVE}};
    end else begin
      sync1 <= switchin;
      sync2 <= sync1;
    end
  end

  assign active = sync2 ^ {CHANNELS{INACTIVE}};

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
    state_t                state;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [LONG_WIDTH-1:0] hold;
    logic                  pressed;
    logic                  press_stb;
    logic                  release_stb;
    logic                  long_hold;

    // Per-channel debounce FSM; all outputs are registered alongside the state.
    always_ff @(posedge chatterclock or posedge reset) begin
      if (reset) begin
        state       <= IDLE;
        cnt         <= '0;
        hold        <= '0;
        pressed     <= 1'b0;
        press_stb   <= 1'b0;
        release_stb <= 1'b0;
        long_hold   <= 1'b0;
      end else begin
        press_stb   <= 1'b0;
        release_stb <= 1'b0;
        case (state)
          IDLE: begin
            cnt  <= '0;
            hold <= '0;
            if (active[ch]) begin
              if (PRESS_COUNT == 1) begin
                state     <= PRESSED;
                pressed   <= 1'b1;
                press_stb <= 1'b1;
              end else begin
                state <= PRESS_WAIT;
                cnt   <= CNT_WIDTH'(1);
              end
            end
          end

          PRESS_WAIT: begin
            if (!active[ch]) begin
              // Any bounce restarts qualification from scratch.
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == PRESS_LAST) begin
              state     <= PRESSED;
              cnt       <= '0;
              pressed   <= 1'b1;
              press_stb <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          PRESSED: begin
            if (hold != LONG_MAX) hold <= hold + 1'b1;
            if (hold >= LONG_LAST) long_hold <= 1'b1;
            if (!active[ch]) begin
              if (RELEASE_COUNT == 1) begin
                state       <= IDLE;
                cnt         <= '0;
                hold        <= '0;
                pressed     <= 1'b0;
                long_hold   <= 1'b0;
                release_stb <= 1'b1;
              end else begin
                state <= RELEASE_WAIT;
                cnt   <= CNT_WIDTH'(1);
              end
            end
          end

          RELEASE_WAIT: begin
            // The hold timer keeps running through a tentative release.
            if (hold != LONG_MAX) hold <= hold + 1'b1;
            if (hold >= LONG_LAST) long_hold <= 1'b1;
            if (active[ch]) begin
              state <= PRESSED;
              cnt   <= '0;
            end else if (cnt == RELEASE_LAST) begin
              state       <= IDLE;
              cnt         <= '0;
              hold        <= '0;
              pressed     <= 1'b0;
              long_hold   <= 1'b0;
              release_stb <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          default: begin
            state <= IDLE;
            cnt   <= '0;
            hold  <= '0;
          end
        endcase
      end
    end

    assign ispressedout[ch]  = pressed;
    assign pressedpulse[ch]  = press_stb;
    assign releasedpulse[ch] = release_stb;
    assign longpressout[ch]  = long_hold;
  end

  // Pure OR of registered levels, so it tracks ispressedout with no extra cycle.
  assign anypressed = |ispressedout;

endmodule

// File: tb/tb_chatter_filter_bank.sv
// Purpose: self-checking bench for chatter_filter_bank (directed scenarios plus randomized run vs. a run-length model).
// Latency: stimulus changes on the falling edge; outputs are sampled on the following falling edge.
// Backpressure: not applicable; the bench drives a new input level every cycle.
module tb_chatter_filter_bank;

  localparam int CH = 4;
  localparam int PC = 30;
  localparam int RC = 30;
  localparam int LC = 1000;

  logic          chatterclock = 1'b0;
  logic          reset        = 1'b1;
  logic [CH-1:0] switchin     = '1;
  logic [CH-1:0] ispressedout;
  logic [CH-1:0] pressedpulse;
  logic [CH-1:0] releasedpulse;
  logic [CH-1:0] longpressout;
  logic          anypressed;

  logic [1:0] f_sw = '0;
  logic [1:0] f_pr;
  logic [1:0] f_pp;
  logic [1:0] f_rp;
  logic [1:0] f_lg;
  logic       f_any;

  int n_vec = 0;
  int n_err = 0;

  always #5 chatterclock = ~chatterclock;

  chatter_filter_bank dut (
    .chatterclock (chatterclock),
    .reset        (reset),
    .switchin     (switchin),
    .ispressedout (ispressedout),
    .pressedpulse (pressedpulse),
    .releasedpulse(releasedpulse),
    .longpressout (longpressout),
    .anypressed   (anypressed)
  );

  chatter_filter_bank #(
    .CHANNELS     (2),
    .ACTIVE_LOW   (0),
    .PRESS_COUNT  (1),
    .RELEASE_COUNT(1),
    .LONG_COUNT   (5)
  ) dut_fast (
    .chatterclock (chatterclock),
    .reset        (reset),
    .switchin     (f_sw),
    .ispressedout (f_pr),
    .pressedpulse (f_pp),
    .releasedpulse(f_rp),
    .longpressout (f_lg),
    .anypressed   (f_any)
  );

  // Reference model: a press is accepted once the delayed input has been active for
  // PC samples in a row, a release once it has been inactive for RC samples in a row.
  logic [CH-1:0] m_s1, m_s2, m_pr, m_pp, m_rp, m_lg;
  int m_arun[CH];
  int m_irun[CH];
  int m_held[CH];

  task automatic model_clear();
    m_s1 = '1;
    m_s2 = '1;
    m_pr = '0;
    m_pp = '0;
    m_rp = '0;
    m_lg = '0;
    for (int c = 0; c < CH; c++) begin
      m_arun[c] = 0;
      m_irun[c] = 0;
      m_held[c] = 0;
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < CH; c++) begin
      logic a;
      a = ~m_s2[c];
      m_pp[c] = 1'b0;
      m_rp[c] = 1'b0;
      if (!m_pr[c]) begin
        m_arun[c] = a ? m_arun[c] + 1 : 0;
        if (m_arun[c] >= PC) begin
          m_pr[c]   = 1'b1;
          m_pp[c]   = 1'b1;
          m_arun[c] = 0;
          m_irun[c] = 0;
          m_held[c] = 0;
        end
      end else begin
        if (m_held[c] < LC) m_held[c] = m_held[c] + 1;
        m_irun[c] = a ? 0 : m_irun[c] + 1;
        if (m_irun[c] >= RC) begin
          m_pr[c]   = 1'b0;
          m_rp[c]   = 1'b1;
          m_lg[c]   = 1'b0;
          m_held[c] = 0;
          m_irun[c] = 0;
          m_arun[c] = 0;
        end else begin
          m_lg[c] = (m_held[c] >= LC);
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = switchin;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge chatterclock or posedge reset);
      if (reset) model_clear();
      else model_edge();
    end
  end

  task automatic tick();
    @(posedge chatterclock);
    @(negedge chatterclock);
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    switchin = '1;
    f_sw     = '0;
    repeat (3) tick();
    n_vec++;
    if ({ispressedout, pressedpulse, releasedpulse, longpressout, anypressed} !== 17'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 0",
               {ispressedout, pressedpulse, releasedpulse, longpressout, anypressed});
    end
    reset = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      n_vec++;
      if ({ispressedout, pressedpulse, releasedpulse, longpressout} !== 16'd0) begin
        n_err++;
        $display("FAIL idle_after_reset cycle %0d: got %h expected 0", n,
                 {ispressedout, pressedpulse, releasedpulse, longpressout});
      end
    end
  endtask

  task automatic test_press_latency();
    switchin[0] = 1'b0;
    for (int n = 0; n <= 32; n++) begin
      tick();
      n_vec++;
      if (ispressedout[0] !== (n >= 31) || pressedpulse[0] !== (n == 31) || releasedpulse[0] !== 1'b0) begin
        n_err++;
        $display("FAIL press_latency edge %0d: pr=%b pp=%b rp=%b expected pr=%b pp=%b rp=0", n,
                 ispressedout[0], pressedpulse[0], releasedpulse[0], n >= 31, n == 31);
      end
    end
    n_vec++;
    if (anypressed !== 1'b1) begin
      n_err++;
      $display("FAIL anypressed_after_press: got %b expected 1", anypressed);
    end
  endtask

  task automatic test_chatter();
    switchin[1] = 1'b0;
    repeat (20) begin
      tick();
      n_vec++;
      if (ispressedout[1] !== 1'b0) begin
        n_err++;
        $display("FAIL chatter_burst: pr=%b expected 0", ispressedout[1]);
      end
    end
    switchin[1] = 1'b1;
    repeat (2) begin
      tick();
      n_vec++;
      if (ispressedout[1] !== 1'b0) begin
        n_err++;
        $display("FAIL chatter_gap: pr=%b expected 0", ispressedout[1]);
      end
    end
    switchin[1] = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      n_vec++;
      if (ispressedout[1] !== (n >= 31) || pressedpulse[1] !== (n == 31)) begin
        n_err++;
        $display("FAIL chatter_requalify edge %0d: pr=%b pp=%b expected pr=%b pp=%b", n,
                 ispressedout[1], pressedpulse[1], n >= 31, n == 31);
      end
    end
  endtask

  task automatic test_glitch();
    switchin[2] = 1'b0;
    repeat (35) tick();
    n_vec++;
    if (ispressedout[2] !== 1'b1) begin
      n_err++;
      $display("FAIL glitch_setup: pr=%b expected 1", ispressedout[2]);
    end
    switchin[2] = 1'b1;
    for (int n = 0; n < 15; n++) begin
      if (n == 5) switchin[2] = 1'b0;
      tick();
      n_vec++;
      if (ispressedout[2] !== 1'b1 || releasedpulse[2] !== 1'b0 || pressedpulse[2] !== 1'b0) begin
        n_err++;
        $display("FAIL glitch_hold cycle %0d: pr=%b rp=%b pp=%b expected 1 0 0", n,
                 ispressedout[2], releasedpulse[2], pressedpulse[2]);
      end
    end
    switchin[2] = 1'b1;
    for (int n = 0; n <= 32; n++) begin
      tick();
      n_vec++;
      if (ispressedout[2] !== (n < 31) || releasedpulse[2] !== (n == 31) || pressedpulse[2] !== 1'b0) begin
        n_err++;
        $display("FAIL release edge %0d: pr=%b rp=%b pp=%b expected pr=%b rp=%b pp=0", n,
                 ispressedout[2], releasedpulse[2], pressedpulse[2], n < 31, n == 31);
      end
    end
  endtask

  task automatic test_long_press();
    switchin[3] = 1'b0;
    for (int n = 0; n < 1100; n++) begin
      tick();
      n_vec++;
      if (ispressedout[3] !== (n >= 31) || longpressout[3] !== (n >= 31 + LC)) begin
        n_err++;
        $display("FAIL long_hold edge %0d: pr=%b lp=%b expected pr=%b lp=%b", n,
                 ispressedout[3], longpressout[3], n >= 31, n >= 31 + LC);
      end
    end
    switchin[3] = 1'b1;
    for (int n = 0; n <= 32; n++) begin
      tick();
      n_vec++;
      if (ispressedout[3] !== (n < 31) || longpressout[3] !== (n < 31) || releasedpulse[3] !== (n == 31)) begin
        n_err++;
        $display("FAIL long_release edge %0d: pr=%b lp=%b rp=%b expected pr=%b lp=%b rp=%b", n,
                 ispressedout[3], longpressout[3], releasedpulse[3], n < 31, n < 31, n == 31);
      end
    end
    // A fresh press must start its hold timer from zero.
    switchin[3] = 1'b0;
    for (int n = 0; n < 130; n++) begin
      tick();
      n_vec++;
      if (ispressedout[3] !== (n >= 31) || longpressout[3] !== 1'b0) begin
        n_err++;
        $display("FAIL long_restart edge %0d: pr=%b lp=%b expected pr=%b lp=0", n,
                 ispressedout[3], longpressout[3], n >= 31);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    switchin = '0;
    repeat (35) tick();
    n_vec++;
    if (ispressedout !== 4'hF || anypressed !== 1'b1) begin
      n_err++;
      $display("FAIL all_pressed: pr=%h any=%b expected F 1", ispressedout, anypressed);
    end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if ({ispressedout, pressedpulse, releasedpulse, longpressout, anypressed} !== 17'd0) begin
      n_err++;
      $display("FAIL async_reset: got %h expected 0",
               {ispressedout, pressedpulse, releasedpulse, longpressout, anypressed});
    end
    for (int n = 0; n < 2; n++) begin
      tick();
      n_vec++;
      if ({ispressedout, pressedpulse, releasedpulse, longpressout, anypressed} !== 17'd0) begin
        n_err++;
        $display("FAIL reset_held cycle %0d: got %h expected 0", n,
                 {ispressedout, pressedpulse, releasedpulse, longpressout, anypressed});
      end
    end
    reset = 1'b0;
    for (int n = 0; n <= 32; n++) begin
      tick();
      n_vec++;
      if (ispressedout !== ((n >= 31) ? 4'hF : 4'h0) || pressedpulse !== ((n == 31) ? 4'hF : 4'h0) ||
          releasedpulse !== 4'h0) begin
        n_err++;
        $display("FAIL requalify_after_reset edge %0d: pr=%h pp=%h rp=%h", n,
                 ispressedout, pressedpulse, releasedpulse);
      end
    end
  endtask

  task automatic test_fast_params();
    f_sw[0] = 1'b1;
    for (int n = 0; n <= 8; n++) begin
      tick();
      n_vec++;
      if (f_pr[0] !== (n >= 2) || f_pp[0] !== (n == 2) || f_rp[0] !== 1'b0 || f_lg[0] !== (n >= 7) ||
          f_any !== (n >= 2)) begin
        n_err++;
        $display("FAIL fast_press edge %0d: pr=%b pp=%b rp=%b lp=%b any=%b", n,
                 f_pr[0], f_pp[0], f_rp[0], f_lg[0], f_any);
      end
    end
    f_sw[0] = 1'b0;
    for (int n = 0; n <= 3; n++) begin
      tick();
      n_vec++;
      if (f_pr[0] !== (n < 2) || f_rp[0] !== (n == 2) || f_pp[0] !== 1'b0 || f_lg[0] !== (n < 2)) begin
        n_err++;
        $display("FAIL fast_release edge %0d: pr=%b pp=%b rp=%b lp=%b", n,
                 f_pr[0], f_pp[0], f_rp[0], f_lg[0]);
      end
    end
    // One-cycle blip: accepted as a press then a release on consecutive edges.
    f_sw[1] = 1'b1;
    for (int n = 0; n <= 4; n++) begin
      tick();
      if (n == 0) f_sw[1] = 1'b0;
      n_vec++;
      if (f_pr[1] !== (n == 2) || f_pp[1] !== (n == 2) || f_rp[1] !== (n == 3)) begin
        n_err++;
        $display("FAIL fast_blip edge %0d: pr=%b pp=%b rp=%b", n, f_pr[1], f_pp[1], f_rp[1]);
      end
    end
  endtask

  task automatic test_random();
    int run[CH];
    for (int c = 0; c < CH; c++) run[c] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < CH; c++) begin
        if (run[c] == 0) begin
          switchin[c] = ~switchin[c];
          run[c] = ($urandom_range(0, 19) == 0) ? 1100 : int'($urandom_range(1, 45));
        end
        run[c] = run[c] - 1;
      end
      if (cyc == 1500) reset = 1'b1;
      if (cyc == 1503) reset = 1'b0;
      tick();
      n_vec++;
      if (ispressedout !== m_pr || anypressed !== (|m_pr)) begin
        n_err++;
        $display("FAIL rand_level cyc %0d: pr=%h any=%b expected %h", cyc, ispressedout, anypressed, m_pr);
      end
      n_vec++;
      if (pressedpulse !== m_pp || releasedpulse !== m_rp) begin
        n_err++;
        $display("FAIL rand_pulse cyc %0d: pp=%h rp=%h expected %h %h", cyc,
                 pressedpulse, releasedpulse, m_pp, m_rp);
      end
      n_vec++;
      if (longpressout !== m_lg) begin
        n_err++;
        $display("FAIL rand_long cyc %0d: lp=%h expected %h", cyc, longpressout, m_lg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_chatter();
    test_glitch();
    test_long_press();
    test_reset_mid_hold();
    test_fast_params();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
